instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PROGRAM_DEPTH, default 64, means the number of 32-bit program words held; it SHALL be a power of two, at least 4.
REQ-002 Parameter, derived: PC_WIDTH = $clog2(PROGRAM_DEPTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- clock_in  in  1  sole clock, rising edge.
- reset_in  in  1  synchronous, active-high reset.
- load_valid_in  in  1  load byte present.
- load_byte_in  in  8  program byte, MSB-first within each word.
- load_ready_out  out  1  block accepts a load byte this cycle.
- load_done_in  in  1  ends the load session.
- clear_in  in  1  discard the program and return to IDLE.
- start_in  in  1  begin execution from word 0.
- instruction_ready_in  in  1  CPU accepts current_instruction_out.
- current_instruction_out  out  32  instruction to the CPU; fields [31:24] write reg, [23:16] read reg1, [15:8] read reg2, [2:0] ALU opcode.
- instruction_valid_out  out  1  current_instruction_out is valid.
- program_counter_out  out  PC_WIDTH  index of the word presented.
- program_length_out  out  PC_WIDTH+1  number of complete words loaded.
- halted_out  out  1  execution finished.

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, RUN and HALTED.
REQ-006 A load byte transfers when load_valid_in and load_ready_out are both high.
REQ-007 load_ready_out SHALL be 1 in IDLE/LOAD while program_length_out < PROGRAM_DEPTH, else 0.
REQ-008 A byte transfer in IDLE SHALL enter LOAD.
REQ-009 A 2-bit byte counter SHALL assemble each word MSB-first; on the 4th byte the word SHALL be written to memory[program_length], program_length SHALL increment, and the counter SHALL wrap to 0.
REQ-010 load_done_in in LOAD SHALL return to IDLE and discard a partial word (counter cleared, length unchanged).
REQ-011 In IDLE, start_in with program_length_out > 0 SHALL enter RUN with pc = 0.
- start_in with length 0 SHALL be ignored.
- start_in SHALL take priority over a simultaneous load byte.
REQ-012 In RUN, memory read is registered: instruction_valid_out SHALL rise 1 cycle after RUN entry and 1 cycle after each accepted transfer.
- It is low during those fetch cycles.
REQ-013 While instruction_valid_out=1 and instruction_ready_in=0, current_instruction_out and program_counter_out SHALL hold stable.
REQ-014 On an accepted transfer (valid & ready), pc SHALL increment.
- If pc was length-1, the FSM SHALL enter HALTED instead; pc does not wrap.
REQ-015 A fetched word equal to HALT_INSTRUCTION (32'hFFFF_FFFF) SHALL NOT be presented; valid stays 0, the FSM enters HALTED, and pc holds its index.
REQ-016 In HALTED:
- halted_out=1 and instruction_valid_out=0.
- start_in SHALL re-enter RUN at pc 0.
- load bytes SHALL be refused.
REQ-017 clear_in in any state SHALL set IDLE with length 0, pc 0, byte counter 0 and valid 0.
- clear_in SHALL override start_in and load in the same cycle.
REQ-018 start_in and load_done_in in RUN or LOAD, other than as stated above, SHALL be ignored.

Reset
REQ-019 reset_in SHALL, synchronously, set state IDLE and outputs as follows:
- current_instruction_out = 0, instruction_valid_out = 0, program_counter_out = 0, program_length_out = 0, halted_out = 0, byte counter 0.
- load_ready_out = 1 from the first cycle after reset.
REQ-020 Reset mid-RUN or mid-LOAD SHALL abort immediately; memory contents need not clear (length 0 makes them unreachable).

Structure
REQ-021 Shared package cpu_pkg SHALL hold:
- INSTRUCTION_WIDTH=32 and HALT_INSTRUCTION.
- Instruction field bit positions (write reg, read reg1, read reg2, opcode).
- The fetch FSM state enum.
REQ-022 Storage SHALL be a sub-module program_memory: a simple dual-port RAM with synchronous write, registered read, and depth PROGRAM_DEPTH.

Verification
REQ-023 Load bytes 01 02 03 04, 05 06 07 08, then load_done, then start:
- program_length_out=2.
- Outputs 32'h01020304 at pc 0, then 32'h05060708 at pc 1, then HALTED.
REQ-024 Hold instruction_ready_in=0 for 5 cycles while valid: the instruction and pc stay constant; after ready, pc advances by exactly 1.
REQ-025 Load words A, FFFFFFFF, B; start: only A is presented, then halted_out=1 with pc=1; B is never valid.
REQ-026 Load PROGRAM_DEPTH words: load_ready_out=0, an extra byte is refused, and length stays PROGRAM_DEPTH.
- Load 6 bytes then load_done: length=1.
REQ-027 Assert reset_in during RUN at pc 3: the next cycle has all outputs 0, state IDLE, and start_in ignored (length 0).
REQ-028 Assert start_in and load_valid_in together in IDLE with length 1: RUN is entered and the byte is not accepted.
- clear_in together with start_in: IDLE, length 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout, the halt encoding and the
// fetch FSM state type used by the instruction fetch unit.
package cpu_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

    localparam int unsigned WRITE_REG_MSB = 31;
    localparam int unsigned WRITE_REG_LSB = 24;
    localparam int unsigned READ_REG1_MSB = 23;
    localparam int unsigned READ_REG1_LSB = 16;
    localparam int unsigned READ_REG2_MSB = 15;
    localparam int unsigned READ_REG2_LSB = 8;
    localparam int unsigned OPCODE_MSB    = 2;
    localparam int unsigned OPCODE_LSB    = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StHalted
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTRUCTION_WIDTH-1:0] instr);
        return instr == HALT_INSTRUCTION;
    endfunction

endpackage

// File: rtl/program_memory.sv
// Simple dual-port program RAM: synchronous write, registered read. The read
// register only updates when rd_en_in is high, so a presented word stays put.
module program_memory
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned DATA_WIDTH = INSTRUCTION_WIDTH
) (
    input  logic                  clock_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  rd_en_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic [DATA_WIDTH-1:0] rd_data_out
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clock_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
        if (rd_en_in) begin
            rd_data_q <= mem_q[rd_addr_in];
        end
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loads a program byte-serially into program_memory and
// then streams it to the CPU over a valid/ready handshake until the end or a HALT word.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PROGRAM_DEPTH = 64,
    parameter int unsigned PC_WIDTH      = $clog2(PROGRAM_DEPTH)
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         load_valid_in,
    input  logic [7:0]                   load_byte_in,
    output logic                         load_ready_out,
    input  logic                         load_done_in,
    input  logic                         clear_in,
    input  logic                         start_in,
    input  logic                         instruction_ready_in,
    output logic [INSTRUCTION_WIDTH-1:0] current_instruction_out,
    output logic                         instruction_valid_out,
    output logic [PC_WIDTH-1:0]          program_counter_out,
    output logic [PC_WIDTH:0]            program_length_out,
    output logic                         halted_out
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH:0]   length_q, length_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         partial_q, partial_d;
    logic                fetched_q, fetched_d;

    logic                         load_ready;
    logic                         take_byte;
    logic                         last_word;
    logic                         instr_valid;
    logic                         mem_we;
    logic                         mem_re;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
    logic [INSTRUCTION_WIDTH-1:0] mem_rdata;

    // Top length bit set means the memory is full.
    assign load_ready  = ((state_q == StIdle) || (state_q == StLoad)) && !length_q[PC_WIDTH];
    assign last_word   = ({1'b0, pc_q} == (length_q - 1'b1));
    assign instr_valid = (state_q == StRun) && fetched_q && !is_halt(mem_rdata);
    assign mem_wdata   = {partial_q, load_byte_in};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        length_d   = length_q;
        byte_cnt_d = byte_cnt_q;
        partial_d  = partial_q;
        fetched_d  = fetched_q;
        take_byte  = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (clear_in) begin
            state_d    = StIdle;
            pc_d       = '0;
            length_d   = '0;
            byte_cnt_d = '0;
            fetched_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_in && (length_q != '0)) begin
                        state_d   = StRun;
                        pc_d      = '0;
                        fetched_d = 1'b0;
                    end else if (load_valid_in && load_ready) begin
                        state_d   = StLoad;
                        take_byte = 1'b1;
                    end
                end
                StLoad: begin
                    if (load_done_in) begin
                        // Any partially assembled word is dropped.
                        state_d    = StIdle;
                        byte_cnt_d = '0;
                    end else if (load_valid_in && load_ready) begin
                        take_byte = 1'b1;
                    end
                end
                StRun: begin
                    if (!fetched_q) begin
                        mem_re    = 1'b1;
                        fetched_d = 1'b1;
                    end else if (is_halt(mem_rdata)) begin
                        state_d   = StHalted;
                        fetched_d = 1'b0;
                    end else if (instruction_ready_in) begin
                        fetched_d = 1'b0;
                        if (last_word) begin
                            state_d = StHalted;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (start_in) begin
                        state_d   = StRun;
                        pc_d      = '0;
                        fetched_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (take_byte) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    mem_we   = 1'b1;
                    length_d = length_q + 1'b1;
                end else begin
                    partial_d = {partial_q[15:0], load_byte_in};
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            length_q   <= '0;
            byte_cnt_q <= '0;
            partial_q  <= '0;
            fetched_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            length_q   <= length_d;
            byte_cnt_q <= byte_cnt_d;
            partial_q  <= partial_d;
            fetched_q  <= fetched_d;
        end
    end

    program_memory #(
        .DEPTH      (PROGRAM_DEPTH),
        .ADDR_WIDTH (PC_WIDTH),
        .DATA_WIDTH (INSTRUCTION_WIDTH)
    ) u_program_memory (
        .clock_in    (clock_in),
        .wr_en_in    (mem_we),
        .wr_addr_in  (length_q[PC_WIDTH-1:0]),
        .wr_data_in  (mem_wdata),
        .rd_en_in    (mem_re),
        .rd_addr_in  (pc_q),
        .rd_data_out (mem_rdata)
    );

    // The instruction bus reads as zero whenever nothing valid is presented.
    assign current_instruction_out = instr_valid ? mem_rdata : '0;
    assign instruction_valid_out   = instr_valid;
    assign program_counter_out     = pc_q;
    assign program_length_out      = length_q;
    assign halted_out              = (state_q == StHalted);
    assign load_ready_out          = load_ready;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: loads small programs byte-serially
// and checks the fetch handshake, halting, capacity limits, clear and reset.
module tb_instruction_fetch_unit;

    localparam int unsigned Depth = 8;
    localparam int unsigned PcW   = $clog2(Depth);

    logic           clk = 1'b0;
    logic           reset_in;
    logic           load_valid_in;
    logic [7:0]     load_byte_in;
    logic           load_ready_out;
    logic           load_done_in;
    logic           clear_in;
    logic           start_in;
    logic           instruction_ready_in;
    logic [31:0]    current_instruction_out;
    logic           instruction_valid_out;
    logic [PcW-1:0] program_counter_out;
    logic [PcW:0]   program_length_out;
    logic           halted_out;

    int checks_done = 0;
    int errors      = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .PROGRAM_DEPTH (Depth)
    ) dut (
        .clock_in                (clk),
        .reset_in                (reset_in),
        .load_valid_in           (load_valid_in),
        .load_byte_in            (load_byte_in),
        .load_ready_out          (load_ready_out),
        .load_done_in            (load_done_in),
        .clear_in                (clear_in),
        .start_in                (start_in),
        .instruction_ready_in    (instruction_ready_in),
        .current_instruction_out (current_instruction_out),
        .instruction_valid_out   (instruction_valid_out),
        .program_counter_out     (program_counter_out),
        .program_length_out      (program_length_out),
        .halted_out              (halted_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_done++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid_in = 1'b1;
        load_byte_in  = b;
        @(negedge clk);
        load_valid_in = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic pulse_done();
        load_done_in = 1'b1;
        @(negedge clk);
        load_done_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic accept();
        instruction_ready_in = 1'b1;
        @(negedge clk);
        instruction_ready_in = 1'b0;
    endtask

    // Called in the fetch cycle: valid must be low now and the word shown next cycle.
    task automatic expect_fetch(input string tag, input logic [31:0] word, input logic [31:0] pc);
        check_eq({tag, "_fetch_low"}, 32'(instruction_valid_out), 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(instruction_valid_out), 32'd1);
        check_eq({tag, "_instr"}, current_instruction_out, word);
        check_eq({tag, "_pc"}, 32'(program_counter_out), pc);
    endtask

    initial begin
        int valid_seen;

        reset_in             = 1'b1;
        load_valid_in        = 1'b0;
        load_byte_in         = 8'h00;
        load_done_in         = 1'b0;
        clear_in             = 1'b0;
        start_in             = 1'b0;
        instruction_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b0;

        check_eq("rst_instr", current_instruction_out, 32'd0);
        check_eq("rst_valid", 32'(instruction_valid_out), 32'd0);
        check_eq("rst_pc", 32'(program_counter_out), 32'd0);
        check_eq("rst_len", 32'(program_length_out), 32'd0);
        check_eq("rst_halted", 32'(halted_out), 32'd0);
        check_eq("rst_ready", 32'(load_ready_out), 32'd1);

        // Two-word program runs to completion.
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        pulse_done();
        check_eq("basic_len", 32'(program_length_out), 32'd2);
        pulse_start();
        expect_fetch("basic0", 32'h0102_0304, 32'd0);
        accept();
        expect_fetch("basic1", 32'h0506_0708, 32'd1);
        accept();
        check_eq("basic_halted", 32'(halted_out), 32'd1);
        check_eq("basic_halt_valid", 32'(instruction_valid_out), 32'd0);
        check_eq("basic_halt_pc", 32'(program_counter_out), 32'd1);
        check_eq("halt_ready", 32'(load_ready_out), 32'd0);
        load_valid_in = 1'b1;
        load_byte_in  = 8'hEE;
        @(negedge clk);
        load_valid_in = 1'b0;
        check_eq("halt_byte_refused", 32'(program_length_out), 32'd2);

        // Restart from HALTED and stall the CPU side for five cycles.
        pulse_start();
        check_eq("restart_halted", 32'(halted_out), 32'd0);
        expect_fetch("hold0", 32'h0102_0304, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(instruction_valid_out), 32'd1);
            check_eq("hold_instr", current_instruction_out, 32'h0102_0304);
            check_eq("hold_pc", 32'(program_counter_out), 32'd0);
        end
        accept();
        check_eq("hold_pc_step", 32'(program_counter_out), 32'd1);
        expect_fetch("hold1", 32'h0506_0708, 32'd1);
        accept();
        check_eq("hold_end_halted", 32'(halted_out), 32'd1);

        // HALT word in the middle stops execution before it is presented.
        pulse_clear();
        check_eq("clr_len", 32'(program_length_out), 32'd0);
        check_eq("clr_halted", 32'(halted_out), 32'd0);
        check_eq("clr_pc", 32'(program_counter_out), 32'd0);
        send_word(32'h1122_3344);
        send_word(32'hFFFF_FFFF);
        send_word(32'hAABB_CCDD);
        pulse_done();
        check_eq("hw_len", 32'(program_length_out), 32'd3);
        pulse_start();
        expect_fetch("hw_a", 32'h1122_3344, 32'd0);
        instruction_ready_in = 1'b1;
        valid_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (instruction_valid_out) valid_seen++;
        end
        instruction_ready_in = 1'b0;
        check_eq("hw_no_valid_after_a", 32'(valid_seen), 32'd0);
        check_eq("hw_halted", 32'(halted_out), 32'd1);
        check_eq("hw_pc", 32'(program_counter_out), 32'd1);

        // Fill the memory, then try one more byte.
        pulse_clear();
        for (int i = 0; i < int'(Depth); i++) begin
            send_word(32'h1000_0000 + 32'(i));
        end
        check_eq("full_ready", 32'(load_ready_out), 32'd0);
        check_eq("full_len", 32'(program_length_out), 32'(Depth));
        load_valid_in = 1'b1;
        load_byte_in  = 8'h99;
        @(negedge clk);
        load_valid_in = 1'b0;
        check_eq("full_extra_len", 32'(program_length_out), 32'(Depth));
        pulse_done();
        check_eq("full_done_len", 32'(program_length_out), 32'(Depth));
        check_eq("full_idle_ready", 32'(load_ready_out), 32'd0);
        pulse_start();
        expect_fetch("full_w0", 32'h1000_0000, 32'd0);

        // Six bytes then done: the trailing partial word is discarded.
        pulse_clear();
        check_eq("clr_run_valid", 32'(instruction_valid_out), 32'd0);
        check_eq("clr_run_len", 32'(program_length_out), 32'd0);
        send_word(32'h2122_2324);
        send_byte(8'h25);
        send_byte(8'h26);
        pulse_done();
        check_eq("partial_len", 32'(program_length_out), 32'd1);
        check_eq("partial_ready", 32'(load_ready_out), 32'd1);
        pulse_start();
        expect_fetch("partial", 32'h2122_2324, 32'd0);
        accept();
        check_eq("partial_halted", 32'(halted_out), 32'd1);
        check_eq("partial_pc", 32'(program_counter_out), 32'd0);

        // start beats a simultaneous load byte in IDLE.
        pulse_clear();
        send_word(32'h3132_3334);
        pulse_done();
        check_eq("prio_len0", 32'(program_length_out), 32'd1);
        start_in      = 1'b1;
        load_valid_in = 1'b1;
        load_byte_in  = 8'h77;
        @(negedge clk);
        start_in      = 1'b0;
        load_valid_in = 1'b0;
        check_eq("prio_len1", 32'(program_length_out), 32'd1);
        check_eq("prio_run_ready", 32'(load_ready_out), 32'd0);
        expect_fetch("prio", 32'h3132_3334, 32'd0);
        accept();
        check_eq("prio_halted", 32'(halted_out), 32'd1);

        // clear beats start.
        clear_in = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        start_in = 1'b0;
        check_eq("cs_len", 32'(program_length_out), 32'd0);
        check_eq("cs_halted", 32'(halted_out), 32'd0);
        check_eq("cs_ready", 32'(load_ready_out), 32'd1);
        @(negedge clk);
        check_eq("cs_valid", 32'(instruction_valid_out), 32'd0);

        // Reset while presenting pc 3.
        for (int i = 0; i < 5; i++) begin
            send_word(32'h0000_00A0 + 32'(i));
        end
        pulse_done();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            expect_fetch("rr_step", 32'h0000_00A0 + 32'(i), 32'(i));
            accept();
        end
        expect_fetch("rr_pc3", 32'h0000_00A3, 32'd3);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        start_in = 1'b1;
        check_eq("rr_instr", current_instruction_out, 32'd0);
        check_eq("rr_valid", 32'(instruction_valid_out), 32'd0);
        check_eq("rr_pc", 32'(program_counter_out), 32'd0);
        check_eq("rr_len", 32'(program_length_out), 32'd0);
        check_eq("rr_halted", 32'(halted_out), 32'd0);
        check_eq("rr_ready", 32'(load_ready_out), 32'd1);
        @(negedge clk);
        start_in = 1'b0;
        check_eq("rr_start_ignored_ready", 32'(load_ready_out), 32'd1);
        check_eq("rr_start_ignored_halted", 32'(halted_out), 32'd0);
        @(negedge clk);
        check_eq("rr_start_ignored_valid", 32'(instruction_valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_done, errors);
        $finish;
    end

endmodule
